// File: rtl/wbu_csr_commit_if.sv
// Bundle between the execution unit, the ID stage CSR read port and the
// write-back/commit stage.
interface wbu_csr_commit_if #(
  parameter int CPU_WIDTH  = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CPU_WIDTH-1:0]  in_pc;
  logic [CPU_WIDTH-1:0]  exu_res;
  logic [CPU_WIDTH-1:0]  csr_res;
  logic                  csr_res_en;
  logic [11:0]           csr_waddr;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  rd_wen;
  logic                  is_ecall;
  logic                  is_mret;
  logic [11:0]           csr_raddr;
  logic [CPU_WIDTH-1:0]  csr_rdata;
  logic                  gpr_wen;
  logic [REG_ADDR_W-1:0] gpr_waddr;
  logic [CPU_WIDTH-1:0]  gpr_wdata;
  logic                  redirect_valid;
  logic [CPU_WIDTH-1:0]  redirect_pc;
  logic                  commit_valid;
  logic [CPU_WIDTH-1:0]  commit_pc;

  modport master (
    output in_valid, in_pc, exu_res, csr_res, csr_res_en, csr_waddr,
           rd_addr, rd_wen, is_ecall, is_mret, csr_raddr,
    input  in_ready, csr_rdata, gpr_wen, gpr_waddr, gpr_wdata,
           redirect_valid, redirect_pc, commit_valid, commit_pc
  );

  modport slave (
    input  in_valid, in_pc, exu_res, csr_res, csr_res_en, csr_waddr,
           rd_addr, rd_wen, is_ecall, is_mret, csr_raddr,
    output in_ready, csr_rdata, gpr_wen, gpr_waddr, gpr_wdata,
           redirect_valid, redirect_pc, commit_valid, commit_pc
  );
endinterface

// File: rtl/wbu_csr_commit.sv
// Write-back/commit stage with machine-mode CSR file and ecall/mret redirects.
// Optional 64-bit mcycle/mcycleh counter enabled by defining WBU_MCYCLE_EN.
module wbu_csr_commit #(
  parameter int                   CPU_WIDTH   = 32,
  parameter int                   REG_ADDR_W  = 5,
  parameter logic [CPU_WIDTH-1:0] MSTATUS_RST = 32'h0000_1800
) (
  input logic            clk,
  input logic            rst_n,
  wbu_csr_commit_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] COMMIT = 1'b1;

  logic [0:0]            state;
  logic [CPU_WIDTH-1:0]  pc_q;
  logic [CPU_WIDTH-1:0]  exu_res_q;
  logic [CPU_WIDTH-1:0]  csr_res_q;
  logic                  csr_en_q;
  logic [11:0]           csr_waddr_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic                  rd_wen_q;
  logic                  ecall_q;
  logic                  mret_q;

  logic [CPU_WIDTH-1:0]  mstatus;
  logic [CPU_WIDTH-1:0]  mtvec;
  logic [CPU_WIDTH-1:0]  mepc;
  logic [CPU_WIDTH-1:0]  mcause;

  logic active;
  logic csr_wr;

  // Reset also masks the commit cycle so a discarded commit never leaks out.
  assign active       = rst_n && (state == COMMIT);
  assign csr_wr       = active && csr_en_q && !ecall_q;
  assign bus.in_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (bus.in_valid) state <= COMMIT;
    end else begin
      state <= IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_ready && bus.in_valid) begin
      pc_q        <= bus.in_pc;
      exu_res_q   <= bus.exu_res;
      csr_res_q   <= bus.csr_res;
      csr_en_q    <= bus.csr_res_en;
      csr_waddr_q <= bus.csr_waddr;
      rd_addr_q   <= bus.rd_addr;
      rd_wen_q    <= bus.rd_wen;
      ecall_q     <= bus.is_ecall;
      mret_q      <= bus.is_mret;
    end
  end

  // ecall takes priority over an explicit CSR write in the same commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus <= MSTATUS_RST;
      mtvec   <= '0;
      mepc    <= '0;
      mcause  <= '0;
    end else if (active && ecall_q) begin
      mepc   <= pc_q;
      mcause <= CPU_WIDTH'(11);
    end else if (csr_wr) begin
      case (csr_waddr_q)
        12'h300: mstatus <= csr_res_q;
        12'h305: mtvec   <= csr_res_q;
        12'h341: mepc    <= csr_res_q;
        12'h342: mcause  <= csr_res_q;
        default: ;
      endcase
    end
  end

`ifdef WBU_MCYCLE_EN
  logic [63:0] mcycle;

  // A written half holds for one cycle; counting resumes afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle <= '0;
    end else if (csr_wr && csr_waddr_q == 12'hB00) begin
      mcycle[31:0] <= csr_res_q[31:0];
    end else if (csr_wr && csr_waddr_q == 12'hB80) begin
      mcycle[63:32] <= csr_res_q[31:0];
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end
`endif

  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_raddr)
      12'h300: bus.csr_rdata = mstatus;
      12'h305: bus.csr_rdata = mtvec;
      12'h341: bus.csr_rdata = mepc;
      12'h342: bus.csr_rdata = mcause;
`ifdef WBU_MCYCLE_EN
      12'hB00: bus.csr_rdata = CPU_WIDTH'(mcycle[31:0]);
      12'hB80: bus.csr_rdata = CPU_WIDTH'(mcycle[63:32]);
`endif
      default: bus.csr_rdata = '0;
    endcase
  end

  always_comb begin
    bus.commit_valid   = 1'b0;
    bus.commit_pc      = '0;
    bus.gpr_wen        = 1'b0;
    bus.gpr_waddr      = '0;
    bus.gpr_wdata      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    if (active) begin
      bus.commit_valid = 1'b1;
      bus.commit_pc    = pc_q;
      bus.gpr_wen      = rd_wen_q && (rd_addr_q != '0);
      bus.gpr_waddr    = rd_addr_q;
      bus.gpr_wdata    = exu_res_q;
      if (ecall_q) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = mtvec;
      end else if (mret_q) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = mepc;
      end
    end
  end

endmodule

// File: doc/wbu_csr_commit.md
Name: wbu_csr_commit

Overview:
- Write-back/commit stage downstream of the execution unit.
- Accepts one executed instruction per valid/ready handshake and holds it in a capture register.
- Commits the result to the GPR write port, updates the machine-mode CSR file and issues PC redirects for ecall/mret.
- Provides the combinational CSR read port that feeds the execution unit's CSR read data input.

Parameters:
- CPU_WIDTH, 32, datapath width.
- REG_ADDR_W, 5, GPR index width.
- MSTATUS_RST, 32'h0000_1800, mstatus reset value.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  EXU result valid.
- in_ready  out  1  WBU can accept.
- in_pc  in  CPU_WIDTH  PC of the instruction.
- exu_res  in  CPU_WIDTH  EXU result destined for rd.
- csr_res  in  CPU_WIDTH  new CSR value.
- csr_res_en  in  1  CSR write request.
- csr_waddr  in  12  CSR address to write.
- rd_addr  in  REG_ADDR_W  destination GPR.
- rd_wen  in  1  GPR write request.
- is_ecall  in  1  instruction is ecall.
- is_mret  in  1  instruction is mret.
- csr_raddr  in  12  CSR read address (from IDU).
- csr_rdata  out  CPU_WIDTH  CSR read data (to EXU data_rd_csr).
- gpr_wen  out  1  GPR write strobe.
- gpr_waddr  out  REG_ADDR_W  GPR write index.
- gpr_wdata  out  CPU_WIDTH  GPR write data.
- redirect_valid  out  1  PC redirect pulse.
- redirect_pc  out  CPU_WIDTH  redirect target.
- commit_valid  out  1  retire pulse.
- commit_pc  out  CPU_WIDTH  PC of the retired instruction.

Behaviour:
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture all inputs and go to COMMIT.
  - COMMIT: in_ready=0. Drive commit outputs for exactly one cycle, then return to IDLE.
- Latency: accepted in cycle N; commit outputs asserted in cycle N+1; CSR writes take effect at the end of cycle N+1. Maximum throughput is one instruction per 2 cycles.
- Outputs in COMMIT:
  - commit_valid=1, commit_pc=captured pc.
  - gpr_wen = rd_wen & (rd_addr!=0), gpr_waddr=rd_addr, gpr_wdata=exu_res.
- Outputs outside COMMIT: all outputs 0 except in_ready.
- CSR file:
  - mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
  - Reset values: mstatus=MSTATUS_RST; mtvec, mepc and mcause = 0.
- CSR write: when csr_res_en, write csr_res to csr_waddr. Writes to unmapped addresses are dropped silently.
- ecall: mepc<=pc, mcause<=32'd11, redirect_valid=1, redirect_pc = mtvec value before the update. ecall overrides any csr_res_en write in the same commit.
- mret: redirect_valid=1, redirect_pc=mepc. No CSR change.
- If is_ecall and is_mret are both set, ecall wins.
- CSR read: csr_rdata is combinational from csr_raddr and reflects committed state. An unmapped address reads 0. There is no bypass of a write that commits in the same cycle.
- Reset:
  - rst_n=0 at any edge, including mid-COMMIT: the FSM returns to IDLE and the pending commit is discarded.
  - No GPR or CSR write occurs in the reset cycle.
  - in_ready=0 while rst_n=0.

Optional Feature:
- Macro: WBU_MCYCLE_EN.
- When defined:
  - Adds a 64-bit cycle counter that increments every non-reset cycle and resets to 0.
  - Readable as mcycle 0xB00 (low word) and mcycleh 0xB80 (high word).
  - A CSR write to either address replaces that half. The written value holds for that cycle; incrementing resumes on the next cycle.
- When undefined: 0xB00 and 0xB80 are unmapped and read 0.

Test Plan:
- Reset, then idle 3 cycles -> csr_rdata(0x300)=0x1800; all commit outputs 0; in_ready=1.
- Accept rd=5, rd_wen=1, exu_res=0xDEADBEEF, pc=0x80000000 -> next cycle gpr_wen=1, gpr_waddr=5, gpr_wdata=0xDEADBEEF, commit_pc=0x80000000; in_ready=0 for that cycle only.
- rd=0, rd_wen=1 -> commit_valid=1, gpr_wen=0.
- csrrw to mtvec=0x80001000, then ecall at pc=0x80000010 -> redirect_pc=0x80001000; mepc reads 0x80000010; mcause reads 11.
- mret after the previous scenario -> redirect_pc=0x80000010; CSRs unchanged.
- Assert rst_n=0 in the COMMIT cycle of a csr_res_en write to mepc=0x1234 -> no gpr_wen; mepc stays 0.
- With WBU_MCYCLE_EN defined: read 0xB00 at two points 10 cycles apart -> difference is 10.
